// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump engine: default widths,
// register count and the FSM state encoding.
package regfile_dump_reader_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int REG_COUNT = 2 ** AW_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready beat stream carrying one (index, value) pair per beat from the
// dump engine (master) to the debug/trace consumer (slave).
interface regfile_dump_reader_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          valid;
    logic          ready;
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;

    modport master (output valid, idx, data, last, input ready);
    modport slave  (input valid, idx, data, last, output ready);
endinterface

// File: rtl/regfile_dump_reader_dump_out_stage.sv
// Single-entry output register: holds a beat stable until the consumer takes
// it, and can accept a new beat in the same cycle the old one is taken.
module dump_out_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         flush,
    input  logic [AW-1:0]                in_idx,
    input  logic [DW-1:0]                in_data,
    input  logic                         in_last,
    output logic                         can_load,
    regfile_dump_reader_if.master        dout
);

    logic          valid_q, valid_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        if (flush) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            idx_d   = in_idx;
            data_d  = in_data;
            last_d  = in_last;
        end else if (valid_q && dout.ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the data register is reset too because the reset value is observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign can_load   = !valid_q || dout.ready;
    assign dout.valid = valid_q;
    assign dout.idx   = idx_q;
    assign dout.data  = data_q;
    assign dout.last  = last_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Scans a contiguous, possibly wrapping, range of register-file entries through
// one read port and streams each (index, value) pair over a valid/ready link.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AW-1:0]         first_idx,
    input  logic [AW-1:0]         last_idx,
    input  logic                  abort,
    output logic [AW-1:0]         ra,
    input  logic [DW-1:0]         busa,
    regfile_dump_reader_if.master dout,
    output logic                  busy,
    output logic                  done
);

    state_e        state_q, state_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [AW:0]   remaining_q, remaining_d;   // one extra bit so a full 32-entry dump fits
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          can_load, load, flush, beat_last;

    assign beat_last = (remaining_q == (AW+1)'(1));

    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    ra_d        = first_idx;
                    remaining_d = {1'b0, last_idx - first_idx} + (AW+1)'(1);
                    busy_d      = 1'b1;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    flush   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (can_load) begin
                    load        = 1'b1;
                    ra_d        = ra_q + AW'(1);
                    remaining_d = remaining_q - (AW+1)'(1);
                    if (beat_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (dout.valid && dout.ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                flush   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ra_q        <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ra_q        <= ra_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Captures busa at the same edge ra advances, so the beat pairs ra_q with its data.
    dump_out_stage #(.DW(DW), .AW(AW)) u_out_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .flush    (flush),
        .in_idx   (ra_q),
        .in_data  (busa),
        .in_last  (beat_last),
        .can_load (can_load),
        .dout     (dout)
    );

    assign ra   = ra_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug and readout engine that scans a contiguous range of architectural registers through one read port of the 32x32 register file.
- Streams each (index, value) pair to a debug/trace consumer over a valid/ready interface.
- Sits beside the CPU datapath. It owns a dedicated read-address port of the register file and never writes.
- Used by the board-level monitor to dump registers x0..x31, or any sub-range, without halting the write port.

Parameters:
- DW, 32, register data width.
- AW, 5, register index width; register count is 2**AW.

Ports:
- clk  in  1  rising-edge clock, shared with the register file.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- first_idx  in  AW  first register index, sampled when start is accepted.
- last_idx  in  AW  last register index, sampled when start is accepted.
- abort  in  1  cancels a dump in progress.
- ra  out  AW  read address to the register file read port.
- busa  in  DW  combinational read data from the register file, equal to regs[ra] in the same cycle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_idx  out  AW  register index of the current beat.
- out_data  out  DW  register value of the current beat.
- out_last  out  1  current beat is the final one of the dump.
- busy  out  1  high from start acceptance until the dump completes or aborts.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async assert, sync-released use): state IDLE; ra=0; out_valid=0; out_idx=0; out_data=0; out_last=0; busy=0; done=0; internal counters 0.
- States:
  - IDLE: start=1 latches first/last, sets ra=first_idx, count=((last_idx-first_idx) mod 2**AW)+1, busy=1, then goes to SCAN.
  - SCAN: capture condition is (!out_valid || out_ready). When it holds, register out_data<=busa, out_idx<=ra, out_valid<=1, out_last<=(remaining==1), ra<=ra+1 (wraps mod 2**AW), remaining<=remaining-1. When the captured beat has out_last=1, go to DRAIN.
  - DRAIN: when out_valid && out_ready, clear out_valid and out_last, pulse done=1 for one cycle, busy<=0, go to IDLE.
- Throughput: one beat per cycle while out_ready is held high. Latency from start to first out_valid is 2 cycles (one edge to enter SCAN, one edge to capture).
- Backpressure: while out_valid && !out_ready, out_idx, out_data and out_last hold stable and ra does not advance.
- Wrap-around: first_idx>last_idx scans first..31 then 0..last_idx. first_idx==last_idx yields exactly 1 beat.
- Coherence: each beat's value is busa sampled at its capture edge. A write committed by the register file at that same edge is not visible in that beat. The engine makes no snapshot guarantee across beats.
- Index 0 is read as the register file returns it; the engine does not force it to zero.
- start while busy is ignored. start and abort both high in IDLE: abort wins and start is dropped.
- abort in SCAN or DRAIN: next edge forces out_valid=0, out_last=0, busy=0 and state IDLE. done is not pulsed, and any pending beat is discarded even if out_ready was high that cycle.
- Reset mid-dump: all outputs return to their reset values immediately, without waiting for a clock edge.
- Arithmetic: ra and index increments are AW-bit modulo. remaining is AW+1 bits so that count=32 is representable.

Decomposition:
- Shared package: state encoding constants (IDLE, SCAN, DRAIN), REG_COUNT=2**AW, and the DW/AW defaults.
- One natural sub-module, dump_out_stage: a single-entry output register with valid/ready hold logic, instantiated once.
- Range counter and FSM stay in the top module.

Test Plan:
- Preload regs[i]=32'h1000_0000+i, start with first=4, last=7, out_ready=1 -> 4 consecutive beats (4,1000_0004)...(7,1000_0007), out_last on idx 7, done pulse 1 cycle later, first beat 2 cycles after start.
- first=30, last=1, out_ready=1 -> beats for idx 30,31,0,1 in that order, 4 beats, out_last on idx 1.
- first=0, last=31 with out_ready toggling 1,0,0,1 -> all 32 beats delivered in order, each held stable while ready=0, no duplicates or drops.
- During a scan, write 32'hDEAD_BEEF to reg 6 at the same edge that beat 6 is captured -> beat 6 carries the old value; a second dump returns DEAD_BEEF.
- Assert abort while beat idx 10 is pending with out_ready=0 -> next cycle out_valid=0 and busy=0, no done; a new start 1 cycle later runs normally.
- Assert rst_n=0 asynchronously mid-scan -> out_valid, busy, done, ra drop to 0 before the next clk edge; start during busy is ignored with no range change.
